// File: rtl/npu_pkg.sv
// Shared NPU types: feed-sequencer state encoding and default drain length.
package npu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/defines.sv
// Global sizing macros shared by the buffer-side blocks.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 6
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 64
`endif

// File: rtl/ub_addr_gen.sv
// One buffer read-address stream: loads base, then steps by a latched stride.
`ifndef ADDR_WIDTH
`include "defines.sv"
`endif

module ub_addr_gen #(
  parameter int unsigned ADDR_W = `ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] stride_q;

  // Address returns to zero whenever the stream is neither loading nor stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (step) begin
      addr     <= addr + stride_q;
    end else begin
      addr     <= '0;
    end
  end

endmodule

// File: rtl/ub_feed_sequencer.sv
// Sequences input/weight buffer reads for one systolic feed job, then drains.
`ifndef ADDR_WIDTH
`include "defines.sv"
`endif

module ub_feed_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned ADDR_W       = `ADDR_WIDTH,
  parameter int unsigned DEPTH        = `BUFFER_DEPTH,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_input_base,
  input  logic [ADDR_W-1:0] cfg_weight_base,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [ADDR_W-1:0] cfg_input_stride,
  input  logic [ADDR_W-1:0] cfg_weight_stride,
  output logic [ADDR_W-1:0] ub_input_addr,
  output logic              ub_input_first,
  output logic              ub_input_last,
  output logic [ADDR_W-1:0] ub_weight_addr,
  output logic              ub_weight_first,
  output logic              ub_weight_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned LW = ADDR_W + 1;
  localparam int unsigned CW = 2 * ADDR_W + 2;
  localparam int unsigned DW = $clog2(DRAIN_CYCLES) + 1;

  feed_state_t state, next_state;

  logic [LW-1:0] len_q;
  logic [LW-1:0] feed_cnt;
  logic [DW-1:0] drain_cnt;
  logic [CW-1:0] in_end, w_end;
  logic          cfg_valid;
  logic          feed_last, drain_last;
  logic          load_gen, step_gen;
  logic          first_d, last_d, busy_d, done_d, err_d;
  logic          marker_first, marker_last;

  // End-row addresses are formed wide enough that no product or sum can wrap.
  always_comb begin
    in_end    = CW'(cfg_input_base) + (CW'(cfg_len) - CW'(1)) * CW'(cfg_input_stride);
    w_end     = CW'(cfg_weight_base) + (CW'(cfg_len) - CW'(1)) * CW'(cfg_weight_stride);
    cfg_valid = (cfg_len != '0) && (in_end < CW'(DEPTH)) && (w_end < CW'(DEPTH));
  end

  assign feed_last  = (feed_cnt == len_q - LW'(1));
  assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && cfg_valid) next_state = FEED;
      FEED:    if (abort) next_state = IDLE;
               else if (feed_last) next_state = DRAIN;
      DRAIN:   if (abort) next_state = IDLE;
               else if (drain_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output values are computed for the upcoming state and registered below.
  always_comb begin
    load_gen = (state == IDLE) && start && cfg_valid;
    step_gen = (state == FEED) && (next_state == FEED);
    first_d  = load_gen;
    if (load_gen) last_d = (cfg_len == LW'(1));
    else          last_d = step_gen && (feed_cnt + LW'(2) == len_q);
    busy_d   = (next_state == FEED) || (next_state == DRAIN);
    done_d   = (next_state == DONE);
    err_d    = (state == IDLE) && start && !cfg_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      feed_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (load_gen) len_q <= cfg_len;
      if (load_gen)      feed_cnt <= '0;
      else if (step_gen) feed_cnt <= feed_cnt + LW'(1);
      if ((state == DRAIN) && (next_state == DRAIN)) drain_cnt <= drain_cnt + DW'(1);
      else                                           drain_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      marker_first <= 1'b0;
      marker_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      marker_first <= first_d;
      marker_last  <= last_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

  assign ub_input_first  = marker_first;
  assign ub_weight_first = marker_first;
  assign ub_input_last   = marker_last;
  assign ub_weight_last  = marker_last;

  ub_addr_gen #(.ADDR_W(ADDR_W)) u_input_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_gen),
    .step   (step_gen),
    .base   (cfg_input_base),
    .stride (cfg_input_stride),
    .addr   (ub_input_addr)
  );

  ub_addr_gen #(.ADDR_W(ADDR_W)) u_weight_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_gen),
    .step   (step_gen),
    .base   (cfg_weight_base),
    .stride (cfg_weight_stride),
    .addr   (ub_weight_addr)
  );

endmodule

// File: doc/ub_feed_sequencer.md
UB_FEED_SEQUENCER -- requirements
Module: ub_feed_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, `ADDR_WIDTH, buffer row address width
- DEPTH, `BUFFER_DEPTH, number of buffer rows
- DRAIN_CYCLES, 16, cycles to wait after the last read before done (pipeline flush of the array)
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, all state updates on posedge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, launch one feed job; sampled in IDLE only
- abort, in, 1, terminate the current job
- cfg_input_base, in, ADDR_W, first input-row address
- cfg_weight_base, in, ADDR_W, first weight-row address
- cfg_len, in, ADDR_W+1, rows per stream (K)
- cfg_input_stride, in, ADDR_W, input address increment per row
- cfg_weight_stride, in, ADDR_W, weight address increment per row
- ub_input_addr, out, ADDR_W, buffer input read address
- ub_input_first, out, 1, first-row marker for the input stream
- ub_input_last, out, 1, last-row marker for the input stream
- ub_weight_addr, out, ADDR_W, buffer weight read address
- ub_weight_first, out, 1, first-row marker for the weight stream
- ub_weight_last, out, 1, last-row marker for the weight stream
- busy, out, 1, high in FEED and DRAIN
- done, out, 1, one-cycle pulse on normal completion
- err, out, 1, one-cycle pulse on a rejected start

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have exactly four states: IDLE, FEED, DRAIN, DONE.
REQ-005 In IDLE with start=1, a valid config SHALL latch all cfg_* values and enter FEED; cfg_* SHALL be ignored afterwards.
REQ-006 Config SHALL be invalid if cfg_len=0, or cfg_input_base+(cfg_len-1)*cfg_input_stride >= DEPTH, or the weight equivalent >= DEPTH. Comparisons SHALL use full-width arithmetic with no truncation.
REQ-007 An invalid start SHALL pulse err in the following cycle and remain in IDLE; no marker SHALL assert.
REQ-008 FEED SHALL last exactly len cycles. In cycle i (i=0..len-1), ub_input_addr SHALL equal input_base+i*input_stride and ub_weight_addr SHALL equal weight_base+i*weight_stride, with no gaps.
REQ-009 The *_first outputs SHALL be high only in FEED cycle 0, and the *_last outputs only in cycle len-1. Both SHALL be high together when len=1.
REQ-010 Input and weight markers SHALL always be identical cycle-for-cycle.
REQ-011 After cycle len-1, the block SHALL enter DRAIN for exactly DRAIN_CYCLES cycles, then DONE for one cycle (done=1), then IDLE.
REQ-012 Outside FEED, all markers SHALL be 0 and both addresses SHALL be 0.
REQ-013 start asserted while busy or in DONE SHALL be ignored, with no err.
REQ-014 abort in FEED or DRAIN SHALL force IDLE on the next edge, with markers and addresses 0, busy=0, and no done. abort in IDLE SHALL have no effect.
REQ-015 When abort and the final FEED cycle coincide, abort SHALL win.
REQ-016 Latency SHALL be as follows: start at edge N gives first-row address/markers valid after edge N+1, so buffer data with markers appears one cycle later.

Reset
REQ-017 rst_n low SHALL asynchronously force IDLE and drive every output to 0, including in mid-job.
REQ-018 After reset release, the first start SHALL behave as in REQ-005..REQ-009.

Structure
REQ-019 The FSM state enum and the DRAIN_CYCLES default SHALL live in the shared package npu_pkg; ADDR_WIDTH and BUFFER_DEPTH SHALL come from defines.sv.
REQ-020 A sub-module ub_addr_gen (base/stride/counter, one instance per stream) SHALL be used; everything else SHALL be flat.

Verification
REQ-021 Directed scenarios, each stimulus -> required response:
- base_in=4, base_w=20, stride=1, len=3 -> in addr 4,5,6 and w addr 20,21,22; first in cycle 0, last in cycle 2; done exactly 3+16+1 cycles after FEED entry.
- len=1, base_in=0 -> first=last=1 in a single cycle; done follows after the drain.
- DEPTH=64, base_in=60, stride=2, len=3 (end 64) -> err pulse, no markers, busy stays 0.
- len=0 -> err pulse; start during busy -> ignored, addresses unaffected.
- abort in FEED cycle 1 of a len=8 job -> markers/addresses 0 next cycle, no done, and a new start is then accepted.
- rst_n low in DRAIN -> all outputs 0 immediately (asynchronous); a rerun with len=2, stride=3 gives addresses base, base+3.
